// File: rtl/fft_radix2_iter.sv
// fft_radix2_iter: iterative in-place radix-2 DIT FFT with one time-shared
// butterfly, a register-file sample buffer and valid/ready streaming ports.
// Optional feature macro: FFT_STAGE_SCALE_EN (per-butterfly 1/2 scaling).
module fft_radix2_iter #(
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned N          = 8,
  parameter int unsigned FRAC_BITS  = 8
) (
  input  logic                    clk,
  input  logic                    arst,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [DATA_WIDTH-1:0]   in_real,
  input  logic [DATA_WIDTH-1:0]   in_imag,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [DATA_WIDTH-1:0]   out_real,
  output logic [DATA_WIDTH-1:0]   out_imag,
  output logic [$clog2(N)-1:0]    out_index,
  output logic                    out_last,
  output logic                    busy,
  output logic                    overflow
);

  localparam int unsigned AW    = $clog2(N);
  localparam int unsigned TW_W  = AW - 1;
  localparam int unsigned BF_W  = AW - 1;
  localparam int unsigned ST_W  = $clog2(AW);
  localparam int unsigned SUM_W = DATA_WIDTH + 2;
  localparam int unsigned PW    = 2 * DATA_WIDTH + 2;

  localparam logic signed [PW-1:0]    RND     = PW'(2 ** (FRAC_BITS - 1));
  localparam logic signed [SUM_W-1:0] SAT_MAX = SUM_W'(2 ** (DATA_WIDTH - 1) - 1);
  localparam logic signed [SUM_W-1:0] SAT_MIN = SUM_W'(-(2 ** (DATA_WIDTH - 1)));

  typedef enum logic [1:0] {S_LOAD, S_COMPUTE, S_UNLOAD} state_t;

  // Elaboration-time cos/sin via Taylor series, rounded to nearest in Q1.FRAC_BITS.
  function automatic int twiddle(input int k, input bit want_sin);
    real ang, term, sum, scale, x;
    ang   = 2.0 * 3.14159265358979323846 * $itor(k) / $itor(N);
    scale = 1.0;
    for (int i = 0; i < int'(FRAC_BITS); i++) scale = scale * 2.0;
    if (want_sin) begin
      term = ang;
      sum  = ang;
      for (int i = 1; i < 24; i++) begin
        term = -term * ang * ang / ($itor(2 * i) * $itor(2 * i + 1));
        sum  = sum + term;
      end
    end else begin
      term = 1.0;
      sum  = 1.0;
      for (int i = 1; i < 24; i++) begin
        term = -term * ang * ang / ($itor(2 * i - 1) * $itor(2 * i));
        sum  = sum + term;
      end
    end
    x = sum * scale;
    if (x >= 0.0) return $rtoi(x + 0.5);
    return -$rtoi(0.5 - x);
  endfunction

  function automatic logic [AW-1:0] bitrev(input logic [AW-1:0] v);
    logic [AW-1:0] r;
    for (int i = 0; i < int'(AW); i++) r[i] = v[int'(AW) - 1 - i];
    return r;
  endfunction

  // Saturate to DATA_WIDTH; MSB of the result flags a clip.
  function automatic logic [DATA_WIDTH:0] sat(input logic signed [SUM_W-1:0] v);
    if (v > SAT_MAX)      return {1'b1, DATA_WIDTH'(SAT_MAX)};
    else if (v < SAT_MIN) return {1'b1, DATA_WIDTH'(SAT_MIN)};
    return {1'b0, DATA_WIDTH'(v)};
  endfunction

  function automatic logic signed [SUM_W-1:0] stage_scale(input logic signed [SUM_W-1:0] v);
`ifdef FFT_STAGE_SCALE_EN
    return (v + SUM_W'(1)) >>> 1;
`else
    return v;
`endif
  endfunction

  logic signed [DATA_WIDTH-1:0] mem_re [N];
  logic signed [DATA_WIDTH-1:0] mem_im [N];
  logic signed [DATA_WIDTH-1:0] tw_re [N/2];
  logic signed [DATA_WIDTH-1:0] tw_im [N/2];

  for (genvar k = 0; k < int'(N / 2); k++) begin : g_tw
    localparam int TW_C = twiddle(k, 1'b0);
    localparam int TW_S = twiddle(k, 1'b1);
    assign tw_re[k] = DATA_WIDTH'(TW_C);
    assign tw_im[k] = DATA_WIDTH'(-TW_S);
  end

  state_t              state, state_nxt;
  logic [AW-1:0]       cnt, cnt_nxt;
  logic [ST_W-1:0]     stage, stage_nxt;
  logic [BF_W-1:0]     bfly, bfly_nxt;
  logic                in_ready_nxt, out_valid_nxt, out_last_nxt, busy_nxt, overflow_nxt;
  logic [DATA_WIDTH-1:0] out_real_nxt, out_imag_nxt;
  logic [AW-1:0]       out_index_nxt;
  logic                load_fire;

  logic [AW-1:0]       span, bf, pos, top_addr, bot_addr;
  logic [TW_W-1:0]     tw_idx;
  logic signed [DATA_WIDTH-1:0] a_re, a_im, b_re, b_im, w_re, w_im;
  logic signed [PW-1:0]    prod_re, prod_im;
  logic signed [SUM_W-1:0] p_re, p_im;
  logic [DATA_WIDTH:0]     s0r, s0i, s1r, s1i;
  logic                    clip_any;

  // Butterfly addressing for (stage, bfly): span = 2^stage.
  always_comb begin
    span     = AW'(1) << stage;
    bf       = AW'(bfly);
    pos      = bf & (span - AW'(1));
    top_addr = ((bf & ~(span - AW'(1))) << 1) | pos;
    bot_addr = top_addr | span;
    tw_idx   = TW_W'(pos << (AW'(AW - 1) - AW'(stage)));
  end

  // Single butterfly: P = W*B rounded, Y0 = A+P, Y1 = A-P, optional scale, saturate.
  always_comb begin
    a_re    = mem_re[top_addr];
    a_im    = mem_im[top_addr];
    b_re    = mem_re[bot_addr];
    b_im    = mem_im[bot_addr];
    w_re    = tw_re[tw_idx];
    w_im    = tw_im[tw_idx];
    prod_re = PW'(b_re) * PW'(w_re) - PW'(b_im) * PW'(w_im);
    prod_im = PW'(b_re) * PW'(w_im) + PW'(b_im) * PW'(w_re);
    p_re    = SUM_W'((prod_re + RND) >>> FRAC_BITS);
    p_im    = SUM_W'((prod_im + RND) >>> FRAC_BITS);
    s0r     = sat(stage_scale(SUM_W'(a_re) + p_re));
    s0i     = sat(stage_scale(SUM_W'(a_im) + p_im));
    s1r     = sat(stage_scale(SUM_W'(a_re) - p_re));
    s1i     = sat(stage_scale(SUM_W'(a_im) - p_im));
    clip_any = s0r[DATA_WIDTH] | s0i[DATA_WIDTH] | s1r[DATA_WIDTH] | s1i[DATA_WIDTH];
  end

  // Next-state and registered-output values for the load/compute/unload sequencer.
  always_comb begin
    state_nxt     = state;
    cnt_nxt       = cnt;
    stage_nxt     = stage;
    bfly_nxt      = bfly;
    in_ready_nxt  = in_ready;
    out_valid_nxt = out_valid;
    out_real_nxt  = out_real;
    out_imag_nxt  = out_imag;
    out_index_nxt = out_index;
    out_last_nxt  = out_last;
    busy_nxt      = busy;
    overflow_nxt  = overflow;
    load_fire     = 1'b0;
    case (state)
      S_LOAD: begin
        load_fire = in_valid && in_ready;
        if (load_fire) begin
          cnt_nxt = cnt + AW'(1);
          if (cnt == AW'(N - 1)) begin
            state_nxt    = S_COMPUTE;
            cnt_nxt      = '0;
            stage_nxt    = '0;
            bfly_nxt     = '0;
            in_ready_nxt = 1'b0;
            busy_nxt     = 1'b1;
            overflow_nxt = 1'b0;
          end
        end
      end
      S_COMPUTE: begin
        overflow_nxt = overflow | clip_any;
        bfly_nxt     = bfly + BF_W'(1);
        if (bfly == BF_W'(N / 2 - 1)) begin
          stage_nxt = stage + ST_W'(1);
          if (stage == ST_W'(AW - 1)) begin
            // Final butterfly writes N/2-1 and N-1, so bin 0 is already settled.
            state_nxt     = S_UNLOAD;
            stage_nxt     = '0;
            out_valid_nxt = 1'b1;
            out_real_nxt  = mem_re[0];
            out_imag_nxt  = mem_im[0];
            out_index_nxt = '0;
            out_last_nxt  = 1'b0;
          end
        end
      end
      S_UNLOAD: begin
        if (out_valid && out_ready) begin
          if (cnt == AW'(N - 1)) begin
            state_nxt     = S_LOAD;
            cnt_nxt       = '0;
            out_valid_nxt = 1'b0;
            out_last_nxt  = 1'b0;
            in_ready_nxt  = 1'b1;
            busy_nxt      = 1'b0;
          end else begin
            cnt_nxt       = cnt + AW'(1);
            out_real_nxt  = mem_re[cnt + AW'(1)];
            out_imag_nxt  = mem_im[cnt + AW'(1)];
            out_index_nxt = cnt + AW'(1);
            out_last_nxt  = (cnt == AW'(N - 2));
          end
        end
      end
      default: state_nxt = S_LOAD;
    endcase
  end

  // State and control/output registers.
  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      state     <= S_LOAD;
      cnt       <= '0;
      stage     <= '0;
      bfly      <= '0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      out_real  <= '0;
      out_imag  <= '0;
      out_index <= '0;
      out_last  <= 1'b0;
      busy      <= 1'b0;
      overflow  <= 1'b0;
    end else begin
      state     <= state_nxt;
      cnt       <= cnt_nxt;
      stage     <= stage_nxt;
      bfly      <= bfly_nxt;
      in_ready  <= in_ready_nxt;
      out_valid <= out_valid_nxt;
      out_real  <= out_real_nxt;
      out_imag  <= out_imag_nxt;
      out_index <= out_index_nxt;
      out_last  <= out_last_nxt;
      busy      <= busy_nxt;
      overflow  <= overflow_nxt;
    end
  end

  // Sample buffer: bit-reversed load writes and in-place butterfly write-back.
  always_ff @(posedge clk) begin
    if (load_fire) begin
      mem_re[bitrev(cnt)] <= in_real;
      mem_im[bitrev(cnt)] <= in_imag;
    end
    if (state == S_COMPUTE) begin
      mem_re[top_addr] <= s0r[DATA_WIDTH-1:0];
      mem_im[top_addr] <= s0i[DATA_WIDTH-1:0];
      mem_re[bot_addr] <= s1r[DATA_WIDTH-1:0];
      mem_im[bot_addr] <= s1i[DATA_WIDTH-1:0];
    end
  end

endmodule
